// File: rtl/wr_resp_order_tracker_pkg.sv
// Shared types and constants for the write-response order tracker.
// Holds the FSM encoding, the AXI BRESP codes and the default tracked-entry layout.
package wr_resp_order_tracker_pkg;

  typedef enum logic {
    RUN = 1'b0,
    ERR = 1'b1
  } ORDER_FSM_T;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_EXOKAY = 2'b01;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  localparam int TRACK_ID_W   = 4;
  localparam int TRACK_USER_W = 2;

  typedef struct packed {
    logic [TRACK_ID_W-1:0]   id;
    logic [TRACK_USER_W-1:0] user;
  } aw_track_t;

endpackage

// File: rtl/wr_resp_order_tracker_track_fifo.sv
// In-order FIFO of accepted write addresses; head is read combinationally so a
// response can be matched in the cycle it arrives. Status outputs are registered.
module track_fifo
  import wr_resp_order_tracker_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = aw_track_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count_next;
  logic           do_push;
  logic           do_pop;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head = mem[rd_ptr];

  always_comb begin
    count_next = count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      full  <= (count_next == (AW+1)'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/wr_resp_order_tracker.sv
// Tracks outstanding AXI writes in issue order, checks each B response against the
// oldest one, throttles AW when tracking is full and counts error responses.
module wr_resp_order_tracker
  import wr_resp_order_tracker_pkg::*;
#(
  parameter int ID_W   = 4,
  parameter int USER_W = 2,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_awvalid,
  output logic                     s_awready,
  input  logic [ID_W-1:0]          s_awid,
  input  logic [USER_W-1:0]        s_awuser,
  output logic                     m_awvalid,
  input  logic                     m_awready,
  input  logic                     bvalid,
  input  logic                     bready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     clr_err,
  output logic [$clog2(DEPTH):0]   outstanding,
  output logic                     full,
  output logic                     empty,
  output logic                     order_err,
  output logic [ID_W-1:0]          err_bid,
  output logic [ID_W-1:0]          err_exp_id,
  output logic [USER_W-1:0]        err_user,
  output logic [CNT_W-1:0]         resp_err_cnt
);

  // Entry layout follows the package aw_track_t, sized by this instance's widths.
  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
  } entry_t;

  entry_t          push_entry;
  entry_t          head;
  logic            push;
  logic            pop;
  logic            b_hs;
  logic            violation;
  logic            bresp_err;
  logic [ID_W-1:0] exp_id;
  logic [USER_W-1:0] exp_user;
  ORDER_FSM_T      state_reg;
  ORDER_FSM_T      state_next;
  logic            capture;
  logic            clear_capture;
  logic [ID_W-1:0]   err_bid_reg;
  logic [ID_W-1:0]   err_exp_id_reg;
  logic [USER_W-1:0] err_user_reg;
  logic [CNT_W-1:0]  resp_err_cnt_reg;

  assign m_awvalid  = s_awvalid & ~full;
  assign s_awready  = m_awready & ~full;
  assign push       = s_awvalid & m_awready & ~full;
  assign push_entry = '{id: s_awid, user: s_awuser};

  assign b_hs      = bvalid & bready;
  assign pop       = b_hs & ~empty;
  assign bresp_err = (bresp >= BRESP_SLVERR);

  // Against an empty FIFO there is no head, so expectations report as zero.
  assign exp_id    = empty ? '0 : head.id;
  assign exp_user  = empty ? '0 : head.user;
  assign violation = b_hs & (empty | (bid != head.id));

  track_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= RUN;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: if (violation) state_next = ERR;
      ERR: if (clr_err && !violation) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    order_err = (state_reg == ERR);
  end

  // First error is kept until cleared; a violation coincident with clr_err re-captures.
  assign capture       = violation & ((state_reg == RUN) | clr_err);
  assign clear_capture = clr_err & ~violation;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_bid_reg    <= '0;
      err_exp_id_reg <= '0;
      err_user_reg   <= '0;
    end else if (capture) begin
      err_bid_reg    <= bid;
      err_exp_id_reg <= exp_id;
      err_user_reg   <= exp_user;
    end else if (clear_capture) begin
      err_bid_reg    <= '0;
      err_exp_id_reg <= '0;
      err_user_reg   <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_cnt_reg <= '0;
    end else if (clr_err) begin
      resp_err_cnt_reg <= (b_hs & bresp_err) ? CNT_W'(1) : '0;
    end else if (b_hs && bresp_err && (resp_err_cnt_reg != '1)) begin
      resp_err_cnt_reg <= resp_err_cnt_reg + CNT_W'(1);
    end
  end

  assign err_bid      = err_bid_reg;
  assign err_exp_id   = err_exp_id_reg;
  assign err_user     = err_user_reg;
  assign resp_err_cnt = resp_err_cnt_reg;

endmodule
